// File: rtl/goose_jump_if.sv
// Goose jump controller bus: physics tick, button and freeze in;
// height, airborne flag and landing pulse out.
interface goose_jump_if #(
  parameter int Y_W = 8
) ();
  logic           jump_tick;
  logic           jump_btn;
  logic           freeze;
  logic [Y_W-1:0] goose_y;
  logic           airborne;
  logic           landed;

  modport master (
    output jump_tick, jump_btn, freeze,
    input  goose_y, airborne, landed
  );

  modport slave (
    input  jump_tick, jump_btn, freeze,
    output goose_y, airborne, landed
  );
endinterface

// File: rtl/goose_jump_ctrl.sv
// Goose jump controller: turns a button press into a parabolic height
// trajectory, one physics step per jump_tick. Rise with decrementing
// velocity, hover at the apex, fall with incrementing velocity.
module goose_jump_ctrl #(
  parameter int Y_W       = 8,
  parameter int V0        = 6,
  parameter int APEX_HOLD = 2
) (
  input logic         clk_in,
  input logic         rst,
  goose_jump_if.slave bus
);

  localparam int H_W = (APEX_HOLD < 1) ? 1 : $clog2(APEX_HOLD + 1);

  localparam logic [Y_W-1:0] ZERO_Y   = {Y_W{1'b0}};
  localparam logic [Y_W-1:0] ONE_Y    = Y_W'(1);
  localparam logic [Y_W-1:0] V0_Y     = Y_W'(V0);
  localparam logic [Y_W-1:0] V0_M1_Y  = Y_W'(V0 - 1);
  localparam logic [H_W-1:0] ZERO_H   = {H_W{1'b0}};
  localparam logic [H_W-1:0] ONE_H    = H_W'(1);
  localparam logic [H_W-1:0] HOLD_MAX = H_W'(APEX_HOLD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    APEX = 2'd2,
    FALL = 2'd3
  } state_t;

  state_t         state_r,  state_s;
  logic [Y_W-1:0] goose_y_r, goose_y_s;
  logic [Y_W-1:0] vel_r,    vel_s;
  logic [H_W-1:0] hold_r,   hold_s;
  logic           req_r,    req_s;
  logic           landed_r, landed_s;
  logic           airborne_r;
  logic           b1_r, b2_r, b3_r;
  logic           edge_s;
  logic [Y_W-1:0] drop_s;

  assign edge_s = b2_r & ~b3_r;
  assign drop_s = vel_r + ONE_Y;

  assign bus.goose_y  = goose_y_r;
  assign bus.airborne = airborne_r;
  assign bus.landed   = landed_r;

  // Button synchronizer plus delay flop for rising-edge detection; runs even when frozen.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      b1_r <= 1'b0;
      b2_r <= 1'b0;
      b3_r <= 1'b0;
    end else begin
      b1_r <= bus.jump_btn;
      b2_r <= b1_r;
      b3_r <= b2_r;
    end
  end

  // Next-state and trajectory arithmetic; only ticks move the goose, freeze holds everything.
  always_comb begin
    state_s   = state_r;
    goose_y_s = goose_y_r;
    vel_s     = vel_r;
    hold_s    = hold_r;
    req_s     = req_r;
    landed_s  = 1'b0;
    if (bus.freeze) begin
      req_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          goose_y_s = ZERO_Y;
          if (bus.jump_tick && (req_r || edge_s)) begin
            goose_y_s = V0_Y;
            vel_s     = V0_M1_Y;
            hold_s    = ZERO_H;
            req_s     = 1'b0;
            if (V0_M1_Y != ZERO_Y) begin
              state_s = RISE;
            end else if (APEX_HOLD != 0) begin
              state_s = APEX;
            end else begin
              state_s = FALL;
            end
          end else if (edge_s) begin
            req_s = 1'b1;
          end else begin
            req_s = req_r;
          end
        end
        RISE: begin
          if (bus.jump_tick) begin
            goose_y_s = goose_y_r + vel_r;
            vel_s     = vel_r - ONE_Y;
            if (vel_r == ONE_Y) begin
              hold_s = ZERO_H;
              if (APEX_HOLD != 0) begin
                state_s = APEX;
              end else begin
                state_s = FALL;
                vel_s   = ZERO_Y;
              end
            end else begin
              state_s = RISE;
            end
          end else begin
            state_s = RISE;
          end
        end
        APEX: begin
          if (bus.jump_tick) begin
            hold_s = hold_r + ONE_H;
            if ((hold_r + ONE_H) == HOLD_MAX) begin
              state_s = FALL;
              vel_s   = ZERO_Y;
            end else begin
              state_s = APEX;
            end
          end else begin
            state_s = APEX;
          end
        end
        FALL: begin
          if (bus.jump_tick) begin
            vel_s = drop_s;
            // Clamp at ground: the last step may overshoot below zero.
            if (goose_y_r <= drop_s) begin
              goose_y_s = ZERO_Y;
              vel_s     = ZERO_Y;
              state_s   = IDLE;
              landed_s  = 1'b1;
            end else begin
              goose_y_s = goose_y_r - drop_s;
            end
          end else begin
            state_s = FALL;
          end
        end
        default: begin
          state_s   = IDLE;
          goose_y_s = ZERO_Y;
          vel_s     = ZERO_Y;
          hold_s    = ZERO_H;
          req_s     = 1'b0;
        end
      endcase
    end
  end

  // State, trajectory and output registers; reset drops the goose to the ground at once.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      goose_y_r  <= ZERO_Y;
      vel_r      <= ZERO_Y;
      hold_r     <= ZERO_H;
      req_r      <= 1'b0;
      landed_r   <= 1'b0;
      airborne_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      goose_y_r  <= goose_y_s;
      vel_r      <= vel_s;
      hold_r     <= hold_s;
      req_r      <= req_s;
      landed_r   <= landed_s;
      airborne_r <= (state_s != IDLE);
    end
  end

endmodule

// File: tb/tb_goose_jump_ctrl.sv
// Scoreboard bench for goose_jump_ctrl: two instances (default physics and
// V0=3/no apex hold) share stimulus; a trajectory model predicts each cycle.
module tb_goose_jump_ctrl;

  logic clk_in = 1'b0;
  logic rst;
  logic btn, tick, frz;

  always #5 clk_in = ~clk_in;

  goose_jump_if #(.Y_W(8)) bus_a ();
  goose_jump_if #(.Y_W(8)) bus_b ();

  assign bus_a.jump_btn  = btn;
  assign bus_a.jump_tick = tick;
  assign bus_a.freeze    = frz;
  assign bus_b.jump_btn  = btn;
  assign bus_b.jump_tick = tick;
  assign bus_b.freeze    = frz;

  goose_jump_ctrl #(.Y_W(8), .V0(6), .APEX_HOLD(2)) dut_a (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus_a.slave)
  );

  goose_jump_ctrl #(.Y_W(8), .V0(3), .APEX_HOLD(0)) dut_b (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus_b.slave)
  );

  typedef struct {
    logic [7:0] y0;
    logic       a0;
    logic       l0;
    logic [7:0] y1;
    logic       a1;
    logic       l1;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a precomputed list of airborne heights per instance,
  // and a position within it (0 = on the ground).
  int traj [2][64];
  int tlen [2];
  int pos  [2];
  bit req  [2];
  bit land [2];
  bit h0, h1, h2;

  function automatic void build(int d, int v0, int hd);
    int y, n, peak, f;
    y = 0;
    n = 0;
    for (int k = 0; k < v0; k++) begin
      y = y + (v0 - k);
      traj[d][n] = y;
      n++;
    end
    peak = y;
    for (int k = 0; k < hd; k++) begin
      traj[d][n] = peak;
      n++;
    end
    for (int k = 1; k <= v0 + 1; k++) begin
      f = peak - (k * (k + 1)) / 2;
      if (f <= 0) break;
      traj[d][n] = f;
      n++;
    end
    tlen[d] = n;
  endfunction

  function automatic int cur_y(int d);
    return (pos[d] == 0) ? 0 : traj[d][pos[d] - 1];
  endfunction

  function automatic void push_exp();
    exp_t ex;
    ex.y0 = 8'(cur_y(0));
    ex.a0 = (pos[0] != 0);
    ex.l0 = land[0];
    ex.y1 = 8'(cur_y(1));
    ex.a1 = (pos[1] != 0);
    ex.l1 = land[1];
    expq.push_back(ex);
  endfunction

  // Advance the model by one clock edge given the inputs seen at that edge.
  function automatic void model_edge(bit b, bit t, bit f, bit r);
    bit e;
    if (r) begin
      h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
      for (int d = 0; d < 2; d++) begin
        pos[d] = 0; req[d] = 1'b0; land[d] = 1'b0;
      end
    end else begin
      e  = h1 & ~h2;
      h2 = h1;
      h1 = h0;
      h0 = b;
      for (int d = 0; d < 2; d++) begin
        land[d] = 1'b0;
        if (f) begin
          req[d] = 1'b0;
        end else if (pos[d] == 0) begin
          if (t && (req[d] || e)) begin
            pos[d] = 1;
            req[d] = 1'b0;
          end else if (e) begin
            req[d] = 1'b1;
          end
        end else if (t) begin
          if (pos[d] == tlen[d]) begin
            pos[d]  = 0;
            land[d] = 1'b1;
          end else begin
            pos[d] = pos[d] + 1;
          end
        end
      end
    end
    push_exp();
  endfunction

  function automatic void check(string nm, logic [7:0] act, logic [7:0] exv);
    checks++;
    if (act !== exv) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exv, $time);
    end
  endfunction

  // Monitor: every falling edge, pop one expected observation and compare both instances.
  always @(negedge clk_in) begin
    exp_t ex;
    if (expq.size() > 0) begin
      ex = expq.pop_front();
      check("goose_y_a",  bus_a.goose_y,            ex.y0);
      check("airborne_a", {7'd0, bus_a.airborne},   {7'd0, ex.a0});
      check("landed_a",   {7'd0, bus_a.landed},     {7'd0, ex.l0});
      check("goose_y_b",  bus_b.goose_y,            ex.y1);
      check("airborne_b", {7'd0, bus_b.airborne},   {7'd0, ex.a1});
      check("landed_b",   {7'd0, bus_b.landed},     {7'd0, ex.l1});
    end
  end

  // One clock cycle: drive after a falling edge, model at the rising edge.
  task automatic step(input bit b, input bit t, input bit f);
    btn  = b;
    tick = t;
    frz  = f;
    @(posedge clk_in);
    model_edge(b, t, f, rst);
    @(negedge clk_in);
  endtask

  task automatic tick_gap(input bit b, input bit f);
    step(b, 1'b1, f);
    repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, f);
  endtask

  task automatic press();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    build(0, 6, 2);
    build(1, 3, 0);
    rst  = 1'b1;
    btn  = 1'b0;
    tick = 1'b0;
    frz  = 1'b0;
    model_edge(1'b0, 1'b0, 1'b0, 1'b1);
    void'(expq.pop_front());
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;

    // Idle: 20 ticks with no press.
    repeat (20) tick_gap(1'b0, 1'b0);

    // Full jump, with presses in RISE and FALL that must be discarded.
    press();
    for (int k = 0; k < 24; k++) tick_gap((k == 2) || (k == 10), 1'b0);

    // Freeze at height 18 in RISE, then resume.
    press();
    n = 0;
    while ((cur_y(0) != 18) && (n < 10)) begin
      tick_gap(1'b0, 1'b0);
      n++;
    end
    if (cur_y(0) != 18) begin
      errors++;
      $display("FAIL reach_rise18 actual=%0d required=18", cur_y(0));
    end
    for (int k = 0; k < 5; k++) tick_gap(1'b0, 1'b1);
    for (int k = 0; k < 16; k++) tick_gap(1'b0, 1'b0);

    // Asynchronous reset at height 15 in FALL.
    press();
    n = 0;
    while (!((pos[0] > 8) && (cur_y(0) == 15)) && (n < 20)) begin
      tick_gap(1'b0, 1'b0);
      n++;
    end
    if (cur_y(0) != 15) begin
      errors++;
      $display("FAIL reach_fall15 actual=%0d required=15", cur_y(0));
    end
    #1 rst = 1'b1;
    #1;
    check("async_rst_y",  bus_a.goose_y,          8'd0);
    check("async_rst_air", {7'd0, bus_a.airborne}, 8'd0);
    check("async_rst_lnd", {7'd0, bus_a.landed},   8'd0);
    step(1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Edge and tick in the same cycle: jump starts on that tick.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) tick_gap(1'b0, 1'b0);

    // Random mix of presses, ticks and freezes.
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 15) == 0));
    end
    step(1'b0, 1'b0, 1'b0);
    @(negedge clk_in);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
